// File: rtl/ifu_axi_master.sv
// rtl/ifu_axi_master.sv - AXI-lite read master for instruction fetch
//
// Purpose:
//   Takes one fetch PC per request, issues a single AR beat to the instruction
//   SRAM, and hands the returned word to decode over a valid/ready pair.
//   Only one transaction is ever outstanding. A flush (redirect) discards any
//   in-flight fetch without breaking the AXI handshake rules. The write
//   channels are tied off.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   pc_valid, pc_ready, pc          fetch request from the PC stage
//   flush                           redirect, kills the in-flight fetch
//   inst_valid, inst_ready          instruction handshake to decode
//   inst, inst_pc, inst_err         fetched word, its PC, access fault flag
//   araddr, arvalid, arready        AXI read address channel
//   rdata, rresp, rvalid, rready    AXI read data channel
//   aw*, w*, b*                     AXI write channels, tied off / ignored

module ifu_axi_master #(
    parameter logic [31:0] INST_NOP = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        pc_valid,
    output logic        pc_ready,
    input  logic [31:0] pc,
    input  logic        flush,

    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_err,

    output logic [31:0] araddr,
    output logic        arvalid,
    input  logic        arready,

    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rvalid,
    output logic        rready,

    output logic [31:0] awaddr,
    output logic        awvalid,
    input  logic        awready,

    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wvalid,
    input  logic        wready,

    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_AR   = 2'd1,
        S_R    = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    // Set when a flush lands while a fetch is on the bus; the response must
    // still be accepted but is then thrown away.
    logic drop;

    logic pc_fire;
    logic pc_misaligned;
    logic ar_fire;
    logic r_fire;
    logic r_discard;

    assign pc_fire       = pc_valid & pc_ready;
    assign pc_misaligned = (pc[1:0] != 2'b00);
    assign ar_fire       = arvalid & arready;
    assign r_fire        = rvalid & rready;
    // A flush arriving in the same cycle as the R handshake also kills the
    // response, otherwise a stale instruction would reach decode.
    assign r_discard     = drop | flush;

    // Write channels are never used.
    assign awaddr  = 32'h0;
    assign awvalid = 1'b0;
    assign wdata   = 32'h0;
    assign wstrb   = 4'h0;
    assign wvalid  = 1'b0;
    assign bready  = 1'b1;

    logic unused_inputs;
    assign unused_inputs = &{1'b0, awready, wready, bresp, bvalid};

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (pc_fire) begin
                    state_nxt = pc_misaligned ? S_HOLD : S_AR;
                end
            end
            S_AR: begin
                if (ar_fire) begin
                    state_nxt = S_R;
                end
            end
            S_R: begin
                if (r_fire) begin
                    state_nxt = r_discard ? S_IDLE : S_HOLD;
                end
            end
            S_HOLD: begin
                if (inst_ready | flush) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output logic: the only combinational output is the request ready
    always_comb begin
        pc_ready = (state == S_IDLE) & ~flush;
    end

    // Registered outputs, updated on the events of the current state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arvalid    <= 1'b0;
            araddr     <= 32'h0;
            rready     <= 1'b0;
            inst_valid <= 1'b0;
            inst       <= INST_NOP;
            inst_pc    <= 32'h0;
            inst_err   <= 1'b0;
            drop       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pc_fire) begin
                        inst_pc <= pc;
                        drop    <= 1'b0;
                        if (pc_misaligned) begin
                            // Fault reported without touching the bus.
                            inst       <= INST_NOP;
                            inst_err   <= 1'b1;
                            inst_valid <= 1'b1;
                        end else begin
                            araddr  <= pc;
                            arvalid <= 1'b1;
                        end
                    end
                end
                S_AR: begin
                    if (flush) begin
                        drop <= 1'b1;
                    end
                    // arvalid/araddr stay put until the slave takes them.
                    if (ar_fire) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                    end
                end
                S_R: begin
                    if (flush) begin
                        drop <= 1'b1;
                    end
                    if (r_fire) begin
                        rready <= 1'b0;
                        if (r_discard) begin
                            drop <= 1'b0;
                        end else begin
                            inst       <= (rresp == 2'b00) ? rdata : INST_NOP;
                            inst_err   <= (rresp != 2'b00);
                            inst_valid <= 1'b1;
                        end
                    end
                end
                S_HOLD: begin
                    if (inst_ready | flush) begin
                        inst_valid <= 1'b0;
                    end
                end
                default: begin
                    arvalid    <= 1'b0;
                    rready     <= 1'b0;
                    inst_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ifu_axi_master.sv
// tb/tb_ifu_axi_master.sv - self-checking bench for ifu_axi_master

module tb_ifu_axi_master;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pc_valid, pc_ready, flush;
    logic [31:0] pc;
    logic        inst_valid, inst_ready, inst_err;
    logic [31:0] inst, inst_pc;
    logic [31:0] araddr;
    logic        arvalid, arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid, rready;
    logic [31:0] awaddr, wdata;
    logic        awvalid, awready, wvalid, wready;
    logic [3:0]  wstrb;
    logic [1:0]  bresp;
    logic        bvalid, bready;

    always #5 clk = ~clk;

    ifu_axi_master #(.INST_NOP(NOP)) dut (
        .clk(clk), .rst_n(rst_n),
        .pc_valid(pc_valid), .pc_ready(pc_ready), .pc(pc), .flush(flush),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
        .inst_pc(inst_pc), .inst_err(inst_err),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Slave configuration, set by the directed tests before each fetch
    logic [31:0] cfg_rdata = 32'h0;
    logic [1:0]  cfg_rresp = 2'b00;
    int          cfg_ar_d  = 0;
    int          cfg_r_d   = 0;

    // Instruction SRAM slave: arready after cfg_ar_d waiting cycles,
    // rvalid cfg_r_d cycles after the AR handshake.
    initial begin
        int ar_cnt;
        int r_cnt;
        bit r_pend;
        bit arhs;
        bit rhs;
        ar_cnt = 0; r_cnt = 0; r_pend = 0;
        arready = 1'b0; rvalid = 1'b0; rdata = 32'h0; rresp = 2'b00;
        forever begin
            @(negedge clk);
            arhs = arvalid && arready;
            rhs  = rvalid && rready;
            @(posedge clk);
            #1;
            if (!rst_n) begin
                arready = 1'b0; rvalid = 1'b0; r_pend = 0; ar_cnt = 0; r_cnt = 0;
            end else begin
                if (rhs) begin
                    rvalid = 1'b0;
                    r_pend = 0;
                end
                if (arhs) begin
                    arready = 1'b0;
                    ar_cnt  = 0;
                    r_pend  = 1;
                    r_cnt   = 0;
                end else if (arvalid) begin
                    if (ar_cnt >= cfg_ar_d) arready = 1'b1;
                    else ar_cnt++;
                end
                if (r_pend && !rvalid) begin
                    if (r_cnt >= cfg_r_d) begin
                        rvalid = 1'b1;
                        rdata  = cfg_rdata;
                        rresp  = cfg_rresp;
                    end else begin
                        r_cnt++;
                    end
                end
            end
        end
    end

    // Transaction-level reference model and per-cycle compare.
    // phase: 0 = no fetch owned, 1 = fetch on the bus, 2 = instruction offered.
    int          phase = 0;
    bit          drop_m = 0;
    int          nar = 0;
    logic [31:0] e_inst, e_pc;
    logic        e_err;
    logic        prev_arv = 1'b0, prev_arr = 1'b0;
    logic [31:0] prev_araddr = 32'h0;
    int          ar_beats = 0;
    int          iv_cycles = 0;

    initial begin
        e_inst = NOP; e_pc = 32'h0; e_err = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                phase = 0; drop_m = 0; prev_arv = 1'b0; prev_arr = 1'b0;
            end else begin
                chk("pc_ready", {31'h0, pc_ready}, {31'h0, (phase == 0) && !flush});
                chk("inst_valid", {31'h0, inst_valid}, {31'h0, phase == 2});
                if (phase == 2) begin
                    chk("inst", inst, e_inst);
                    chk("inst_pc", inst_pc, e_pc);
                    chk("inst_err", {31'h0, inst_err}, {31'h0, e_err});
                end
                if (phase != 1) begin
                    chk("arvalid_quiet", {31'h0, arvalid}, 32'h0);
                    chk("rready_quiet", {31'h0, rready}, 32'h0);
                end
                if (prev_arv && !prev_arr) begin
                    chk("arvalid_hold", {31'h0, arvalid}, 32'h1);
                    chk("araddr_hold", araddr, prev_araddr);
                end
                if (inst_valid) iv_cycles++;
                if (arvalid && arready) ar_beats++;

                case (phase)
                    0: begin
                        if (pc_valid && !flush) begin
                            e_pc = pc;
                            if (pc[1:0] != 2'b00) begin
                                e_inst = NOP;
                                e_err  = 1'b1;
                                phase  = 2;
                            end else begin
                                drop_m = 0;
                                nar    = 0;
                                phase  = 1;
                            end
                        end
                    end
                    1: begin
                        if (flush) drop_m = 1;
                        if (arvalid && arready) begin
                            nar++;
                            chk("ar_addr", araddr, e_pc);
                            chk("ar_beats_per_fetch", nar, 1);
                        end
                        if (rvalid && rready) begin
                            chk("r_after_ar", nar, 1);
                            if (drop_m) begin
                                phase = 0;
                            end else begin
                                e_inst = (rresp == 2'b00) ? rdata : NOP;
                                e_err  = (rresp != 2'b00);
                                phase  = 2;
                            end
                        end
                    end
                    default: begin
                        if (flush || inst_ready) phase = 0;
                    end
                endcase
                prev_arv    = arvalid;
                prev_arr    = arready;
                prev_araddr = araddr;
            end
        end
    end

    task automatic send_pc(input logic [31:0] a);
        bit got;
        int k;
        got = 0; k = 0;
        @(posedge clk); #1;
        pc_valid = 1'b1;
        pc = a;
        while (!got && k < 50) begin
            @(negedge clk);
            k++;
            got = pc_ready;
        end
        if (!got) chk("pc_accept_timeout", 32'h0, 32'h1);
        @(posedge clk); #1;
        pc_valid = 1'b0;
    endtask

    task automatic wait_inst(output int n);
        bit got;
        got = 0; n = 0;
        while (!got && n < 60) begin
            @(negedge clk);
            n++;
            got = inst_valid;
        end
        if (!got) chk("inst_timeout", 32'h0, 32'h1);
    endtask

    task automatic idu_accept(input int d);
        repeat (d) @(negedge clk);
        @(posedge clk); #1;
        inst_ready = 1'b1;
        @(posedge clk); #1;
        inst_ready = 1'b0;
    endtask

    task automatic wait_rready();
        bit got;
        int k;
        got = 0; k = 0;
        while (!got && k < 50) begin
            @(negedge clk);
            k++;
            got = rready;
        end
        if (!got) chk("rready_timeout", 32'h0, 32'h1);
    endtask

    task automatic wait_rfire();
        bit got;
        int k;
        got = 0; k = 0;
        while (!got && k < 50) begin
            @(negedge clk);
            k++;
            got = rvalid && rready;
        end
        if (!got) chk("rfire_timeout", 32'h0, 32'h1);
    endtask

    task automatic set_slave(input logic [31:0] d, input logic [1:0] r, input int ad, input int rd);
        cfg_rdata = d;
        cfg_rresp = r;
        cfg_ar_d  = ad;
        cfg_r_d   = rd;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int b;
        int iv;
        int cnt;
        logic [1:0] bad_resp [2];
        bad_resp[0] = 2'b01;
        bad_resp[1] = 2'b11;

        pc_valid = 1'b0; pc = 32'h0; flush = 1'b0; inst_ready = 1'b0;
        awready = 1'b0; wready = 1'b0; bresp = 2'b00; bvalid = 1'b0;

        // Reset state
        #12;
        chk("rst_arvalid", {31'h0, arvalid}, 32'h0);
        chk("rst_araddr", araddr, 32'h0);
        chk("rst_rready", {31'h0, rready}, 32'h0);
        chk("rst_inst_valid", {31'h0, inst_valid}, 32'h0);
        chk("rst_inst", inst, NOP);
        chk("rst_inst_pc", inst_pc, 32'h0);
        chk("rst_inst_err", {31'h0, inst_err}, 32'h0);
        chk("rst_pc_ready", {31'h0, pc_ready}, 32'h1);
        chk("tie_awvalid", {31'h0, awvalid}, 32'h0);
        chk("tie_wvalid", {31'h0, wvalid}, 32'h0);
        chk("tie_wstrb", {28'h0, wstrb}, 32'h0);
        chk("tie_bready", {31'h0, bready}, 32'h1);
        @(posedge clk); #3;
        rst_n = 1'b1;

        // 1. Minimum-latency fetch
        set_slave(32'h0010_0093, 2'b00, 0, 0);
        send_pc(32'h8000_0000);
        wait_inst(n);
        chk("t1_latency", n, 3);
        chk("t1_inst", inst, 32'h0010_0093);
        chk("t1_inst_pc", inst_pc, 32'h8000_0000);
        chk("t1_inst_err", {31'h0, inst_err}, 32'h0);
        idu_accept(0);
        @(negedge clk);
        chk("t1_pc_ready_after", {31'h0, pc_ready}, 32'h1);

        // 2. Stalls on AR, R and the IDU side
        set_slave(32'h0020_8113, 2'b00, 4, 3);
        b = ar_beats;
        send_pc(32'h8000_0010);
        wait_inst(n);
        chk("t2_latency", n, 10);
        chk("t2_inst", inst, 32'h0020_8113);
        idu_accept(2);
        chk("t2_single_ar", ar_beats - b, 1);

        // 3. Flush while waiting for R
        set_slave(32'hDEAD_BEEF, 2'b00, 0, 2);
        iv = iv_cycles;
        send_pc(32'h8000_0000);
        wait_rready();
        @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        wait_rfire();
        @(negedge clk);
        chk("t3_pc_ready_next", {31'h0, pc_ready}, 32'h1);
        chk("t3_no_inst", iv_cycles - iv, 0);
        set_slave(32'h0041_8193, 2'b00, 0, 0);
        send_pc(32'h8000_0004);
        wait_inst(n);
        chk("t3_next_inst", inst, 32'h0041_8193);
        chk("t3_next_pc", inst_pc, 32'h8000_0004);
        idu_accept(0);

        // 4. Flush while AR is stalled
        set_slave(32'h1234_5678, 2'b00, 3, 0);
        iv = iv_cycles;
        send_pc(32'h8000_0020);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        cnt = 1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (!arvalid) break;
            cnt++;
        end
        chk("t4_arvalid_cycles", cnt, 4);
        repeat (2) @(negedge clk);
        chk("t4_no_inst", iv_cycles - iv, 0);
        chk("t4_pc_ready", {31'h0, pc_ready}, 32'h1);

        // 5. Error responses and a misaligned PC
        set_slave(32'hABCD_0000, 2'b10, 0, 0);
        send_pc(32'h8000_0030);
        wait_inst(n);
        chk("t5_latency", n, 3);
        chk("t5_inst", inst, NOP);
        chk("t5_inst_err", {31'h0, inst_err}, 32'h1);
        idu_accept(0);
        for (int i = 0; i < 2; i++) begin
            set_slave(32'h5555_AAAA, bad_resp[i], 0, 0);
            send_pc(32'h8000_0034);
            wait_inst(n);
            chk("t5_resp_err", {31'h0, inst_err}, 32'h1);
            chk("t5_resp_inst", inst, NOP);
            idu_accept(0);
        end
        set_slave(32'h0000_0000, 2'b00, 0, 0);
        b = ar_beats;
        send_pc(32'h8000_0002);
        wait_inst(n);
        chk("t5_mis_latency", n, 1);
        chk("t5_mis_err", {31'h0, inst_err}, 32'h1);
        chk("t5_mis_inst", inst, NOP);
        chk("t5_mis_pc", inst_pc, 32'h8000_0002);
        idu_accept(0);
        chk("t5_mis_no_ar", ar_beats - b, 0);

        // 7. Flush while an instruction is offered
        set_slave(32'h0000_0517, 2'b00, 0, 0);
        send_pc(32'h8000_0040);
        wait_inst(n);
        chk("t7_inst", inst, 32'h0000_0517);
        @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        chk("t7_flushed", {31'h0, inst_valid}, 32'h0);

        // 6. Asynchronous reset in R
        set_slave(32'h7777_7777, 2'b00, 0, 5);
        send_pc(32'h8000_0050);
        wait_rready();
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_arvalid", {31'h0, arvalid}, 32'h0);
        chk("t6_rready", {31'h0, rready}, 32'h0);
        chk("t6_inst_valid", {31'h0, inst_valid}, 32'h0);
        chk("t6_araddr", araddr, 32'h0);
        chk("t6_inst_pc", inst_pc, 32'h0);
        chk("t6_inst", inst, NOP);
        @(posedge clk);
        @(posedge clk); #3;
        rst_n = 1'b1;
        set_slave(32'h00C5_8593, 2'b00, 0, 0);
        send_pc(32'h8000_0060);
        wait_inst(n);
        chk("t6_after_latency", n, 3);
        chk("t6_after_inst", inst, 32'h00C5_8593);
        chk("t6_after_pc", inst_pc, 32'h8000_0060);
        idu_accept(0);
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
